// File: rtl/xbar_rr_arbiter.sv
// Registered round-robin ownership arbiter for the two slave ports of a 2x2 crossbar.
// Optional forced release on a stalled owner is enabled with `define XBAR_TIMEOUT_EN.
module xbar_rr_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] m_req,
    input  logic [1:0] m_sel,
    input  logic [1:0] s_ack,
    output logic [1:0] grant_s1,
    output logic [1:0] grant_s2,
    output logic       last_s1,
    output logic       last_s2,
    output logic [1:0] timeout_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    for (genvar k = 0; k < 2; k++) begin : g_eng
        state_t     state_q, state_d;
        logic       owner_q, owner_d;
        logic       last_q, last_d;
        logic [1:0] cand;
        logic       arb_valid, arb_pick;
        logic       release_c, expire;
        logic [1:0] grant_c;
        logic       tmo_q;

        assign cand = m_req & {m_sel[1] == 1'(k), m_sel[0] == 1'(k)};

        // While OWNED, last_q always equals owner_q, so this one picker
        // serves both the IDLE tie-break and the same-edge handoff on release.
        always_comb begin
            arb_valid = |cand;
            if (&cand) arb_pick = ~last_q;
            else       arb_pick = cand[1];
        end

`ifdef XBAR_TIMEOUT_EN
        logic [7:0] cnt_q;

        // An ack in the expiring cycle takes priority and suppresses the error.
        assign expire = (state_q == OWNED) && !s_ack[k] &&
                        (cnt_q == 8'(TIMEOUT_CYCLES - 1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                tmo_q <= 1'b0;
            end else begin
                tmo_q <= expire;
                if (state_d == OWNED && (state_q == IDLE || release_c))
                    cnt_q <= '0;
                else if (state_q == OWNED && !s_ack[k])
                    cnt_q <= cnt_q + 8'd1;
            end
        end
`else
        assign expire = 1'b0;
        assign tmo_q  = 1'b0;
`endif

        // NOTE: every output of this block gets a default first so no path
        // through the case leaves a variable unassigned (no latch inferred).
        always_comb begin
            state_d   = state_q;
            owner_d   = owner_q;
            last_d    = last_q;
            release_c = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        state_d = OWNED;
                        owner_d = arb_pick;
                        last_d  = arb_pick;
                    end
                end
                OWNED: begin
                    release_c = s_ack[k] | ~cand[owner_q] | expire;
                    if (release_c) begin
                        if (arb_valid) begin
                            owner_d = arb_pick;
                            last_d  = arb_pick;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // NOTE: state registers use non-blocking assignments so every engine
        // samples the pre-edge values of its neighbours and of the inputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                owner_q <= 1'b0;
                last_q  <= 1'b1;
            end else begin
                state_q <= state_d;
                owner_q <= owner_d;
                last_q  <= last_d;
            end
        end

        assign grant_c = (state_q == OWNED) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    end

    assign grant_s1    = g_eng[0].grant_c;
    assign grant_s2    = g_eng[1].grant_c;
    assign last_s1     = g_eng[0].last_q;
    assign last_s2     = g_eng[1].last_q;
    assign timeout_err = {g_eng[1].tmo_q, g_eng[0].tmo_q};

endmodule

// File: tb/tb_xbar_rr_arbiter.sv
// Scoreboard bench for xbar_rr_arbiter: directed handoff/release/reset cases plus a
// model-checked random phase. Define XBAR_TIMEOUT_EN to exercise forced release.
module tb_xbar_rr_arbiter;

`ifdef XBAR_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] m_req = '0;
    logic [1:0] m_sel = '0;
    logic [1:0] s_ack = '0;
    logic [1:0] grant_s1, grant_s2, timeout_err;
    logic       last_s1, last_s2;

    xbar_rr_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_req       (m_req),
        .m_sel       (m_sel),
        .s_ack       (s_ack),
        .grant_s1    (grant_s1),
        .grant_s2    (grant_s2),
        .last_s1     (last_s1),
        .last_s2     (last_s2),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Observation word: {grant_s2, grant_s1, last_s2, last_s1, timeout_err}.
    function automatic logic [7:0] pk(input logic [1:0] g1, input logic [1:0] g2,
                                      input logic l1, input logic l2, input logic [1:0] err);
        return {g2, g1, l2, l1, err};
    endfunction

    function automatic logic [7:0] observe();
        return {grant_s2, grant_s1, last_s2, last_s1, timeout_err};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got g2/g1/l2/l1/err=%b expected %b", tag, got, exp);
    endtask

    task automatic pop_and_check();
        sb_entry_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", observe(), 8'hxx);
            return;
        end
        e = sb_q.pop_front();
        check(e.tag, observe(), e.exp);
    endtask

    // Drive one cycle of inputs, queue the value expected after the next edge, then compare.
    task automatic step(input string tag, input logic [1:0] req, input logic [1:0] sel,
                        input logic [1:0] ack, input logic [7:0] exp);
        sb_entry_t e;
        m_req = req;
        m_sel = sel;
        s_ack = ack;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        pop_and_check();
    endtask

    // Reference model state, per slave.
    logic       m_v[2];
    logic       m_o[2];
    logic       m_l[2];
    logic [7:0] m_c[2];
    logic [1:0] m_e;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 1'b0;
            m_o[k] = 1'b0;
            m_l[k] = 1'b1;
            m_c[k] = '0;
        end
        m_e = '0;
    endtask

    task automatic model_step(input logic [1:0] req, input logic [1:0] sel,
                              input logic [1:0] ack, output logic [7:0] exp);
        logic [1:0] cand;
        logic       expire, keep, pref;
        logic [1:0] g[2];
        for (int k = 0; k < 2; k++) begin
            cand[0] = req[0] && (sel[0] == k[0]);
            cand[1] = req[1] && (sel[1] == k[0]);
            expire  = 1'b0;
            keep    = 1'b0;
            if (m_v[k]) begin
`ifdef XBAR_TIMEOUT_EN
                if (!ack[k] && m_c[k] == 8'(TMO - 1)) expire = 1'b1;
`endif
                keep = !ack[k] && cand[m_o[k]] && !expire;
            end
            m_e[k] = expire;
            if (keep) begin
                m_c[k] = m_c[k] + 8'd1;
            end else begin
                pref = !m_l[k];
                if (cand[pref]) begin
                    m_v[k] = 1'b1; m_o[k] = pref; m_l[k] = pref; m_c[k] = '0;
                end else if (cand[m_l[k]]) begin
                    m_v[k] = 1'b1; m_o[k] = m_l[k]; m_c[k] = '0;
                end else begin
                    m_v[k] = 1'b0;
                end
            end
            g[k] = m_v[k] ? (m_o[k] ? 2'b10 : 2'b01) : 2'b00;
        end
        exp = pk(g[0], g[1], m_l[0], m_l[1], m_e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [7:0] exp;
        logic [1:0] r, s, a;

        #12;
        check("reset_state", observe(), pk(2'b00, 2'b00, 1'b1, 1'b1, 2'b00));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step("grant_m1",   2'b11, 2'b00, 2'b00, pk(2'b01, 2'b00, 1'b0, 1'b1, 2'b00));
        step("handoff_m2", 2'b11, 2'b00, 2'b01, pk(2'b10, 2'b00, 1'b1, 1'b1, 2'b00));
        step("handoff_m1", 2'b11, 2'b00, 2'b01, pk(2'b01, 2'b00, 1'b0, 1'b1, 2'b00));
        step("hold_owner", 2'b11, 2'b00, 2'b00, pk(2'b01, 2'b00, 1'b0, 1'b1, 2'b00));
        step("all_drop",   2'b00, 2'b00, 2'b00, pk(2'b00, 2'b00, 1'b0, 1'b1, 2'b00));
        step("parallel",   2'b11, 2'b10, 2'b00, pk(2'b01, 2'b10, 1'b0, 1'b1, 2'b00));
        step("s1_release", 2'b11, 2'b11, 2'b01, pk(2'b00, 2'b10, 1'b0, 1'b1, 2'b00));
        step("s2_handoff", 2'b11, 2'b11, 2'b10, pk(2'b00, 2'b01, 1'b0, 1'b0, 2'b00));
        step("owner_drop", 2'b00, 2'b11, 2'b00, pk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00));

`ifdef XBAR_TIMEOUT_EN
        step("tmo_grant",  2'b10, 2'b00, 2'b00, pk(2'b10, 2'b00, 1'b1, 1'b0, 2'b00));
        for (int i = 0; i < 3; i++)
            step("tmo_wait", 2'b11, 2'b00, 2'b00, pk(2'b10, 2'b00, 1'b1, 1'b0, 2'b00));
        step("tmo_fire",   2'b11, 2'b00, 2'b00, pk(2'b01, 2'b00, 1'b0, 1'b0, 2'b01));
        step("tmo_pulse1", 2'b11, 2'b00, 2'b00, pk(2'b01, 2'b00, 1'b0, 1'b0, 2'b00));
        for (int i = 0; i < 2; i++)
            step("tmo_wait2", 2'b11, 2'b00, 2'b00, pk(2'b01, 2'b00, 1'b0, 1'b0, 2'b00));
        step("tmo_ack_wins", 2'b11, 2'b00, 2'b01, pk(2'b10, 2'b00, 1'b1, 1'b0, 2'b00));
        step("tmo_no_err", 2'b11, 2'b00, 2'b00, pk(2'b10, 2'b00, 1'b1, 1'b0, 2'b00));
`endif

        step("crossed",    2'b11, 2'b01, 2'b00, pk(2'b10, 2'b01, 1'b1, 1'b0, 2'b00));
`ifndef XBAR_TIMEOUT_EN
        for (int i = 0; i < 20; i++)
            step("held_no_ack", 2'b11, 2'b01, 2'b00, pk(2'b10, 2'b01, 1'b1, 1'b0, 2'b00));
`endif

        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", observe(), pk(2'b00, 2'b00, 1'b1, 1'b1, 2'b00));
        @(posedge clk);
        #1;
        check("reset_held", observe(), pk(2'b00, 2'b00, 1'b1, 1'b1, 2'b00));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 400; i++) begin
            r = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) r = r | 2'b01;
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) s = ~s;
            a[0] = ($urandom_range(0, 4) == 0);
            a[1] = ($urandom_range(0, 4) == 0);
            model_step(r, s, a, exp);
            step("random", r, s, a, exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
